spi_master_queue: RTL and testbench

Byte-stream front end for the SPI master FSM. It buffers outgoing bytes in a TX FIFO and issues one single-cycle start pulse per byte, holding the data stable for the master. It waits for the master's done pulse, then pushes the received byte into an RX FIFO. It sits between the system-side valid/ready interfaces and the master's start/data_in/data_out/done ports, all in the clk domain.

---
 rtl/spi_master_queue_pkg.sv | 11 +
 rtl/spi_sync_fifo.sv | 59 +++++
 rtl/spi_master_queue.sv | 106 ++++++++++
 tb/tb_spi_master_queue.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_queue_pkg.sv
// Shared definitions for the SPI byte-queue front end: byte width and FSM state encoding.
package spi_master_queue_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with wrapping pointers and an occupancy counter; head is read straight from memory.
module spi_sync_fifo
    import spi_master_queue_pkg::*;
#(
    parameter int WIDTH = SPI_BYTE_W,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/spi_master_queue.sv
// Byte-stream front end for the SPI master: TX FIFO feeds one start pulse per byte, replies land in an RX FIFO.
module spi_master_queue
    import spi_master_queue_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  tx_valid,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  rx_valid,
    output logic [SPI_BYTE_W-1:0] rx_data,
    input  logic                  rx_ready,
    output logic [AW:0]           tx_level,
    output logic [AW:0]           rx_level,
    output logic                  busy,
    output logic                  timeout_err,
    output logic                  m_start,
    output logic [SPI_BYTE_W-1:0] m_data_in,
    input  logic [SPI_BYTE_W-1:0] m_data_out,
    input  logic                  m_done
);

    localparam int CW = $clog2(TIMEOUT);

    state_t                  state;
    logic [CW-1:0]           to_cnt;
    logic                    tx_full;
    logic                    tx_empty;
    logic                    rx_full;
    logic                    rx_empty;
    logic [SPI_BYTE_W-1:0]   tx_head;
    logic                    launch;
    logic                    rx_push;

    // RX space is checked at launch; with one transfer in flight the reply always fits.
    assign launch   = (state == ST_IDLE) & enable & ~tx_empty & ~rx_full;
    assign rx_push  = (state == ST_WAIT) & m_done;
    assign tx_ready = ~tx_full;
    assign rx_valid = ~rx_empty;
    assign busy     = (state == ST_WAIT);

    spi_sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_valid),
        .din   (tx_data),
        .full  (tx_full),
        .pop   (launch),
        .dout  (tx_head),
        .empty (tx_empty),
        .level (tx_level)
    );

    spi_sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .din   (m_data_out),
        .full  (rx_full),
        .pop   (rx_ready),
        .dout  (rx_data),
        .empty (rx_empty),
        .level (rx_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            to_cnt      <= '0;
            m_start     <= 1'b0;
            m_data_in   <= '0;
            timeout_err <= 1'b0;
        end else begin
            m_start     <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        m_start   <= 1'b1;
                        m_data_in <= tx_head;
                        to_cnt    <= '0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (m_done) begin
                        state <= ST_IDLE;
                    end else if (to_cnt == CW'(TIMEOUT - 1)) begin
                        // Master never answered: drop the byte and free the queue.
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_queue.sv
// Directed bench for spi_master_queue with a simple SPI master model that answers data ^ 8'h99.
module tb_spi_master_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [3:0] tx_level;
    logic [3:0] rx_level;
    logic       busy;
    logic       timeout_err;
    logic       m_start;
    logic [7:0] m_data_in;
    logic [7:0] m_data_out;
    logic       m_done;

    int tests = 0;
    int fails = 0;

    logic       mdl_done;
    logic       mdl_busy;
    int         mdl_cnt;
    logic [7:0] mdl_cap;
    logic       prev_start;
    int         mdl_delay = 2;
    logic       master_respond = 1'b1;
    logic       spurious_done = 1'b0;
    int         start_count = 0;
    int         start_in_wait = 0;
    int         dbl_start = 0;
    int         to_count = 0;
    int         start_cyc = 0;
    int         to_cyc = 0;
    int         cyc = 0;
    logic [7:0] start_log [$];

    assign m_done = mdl_done | spurious_done;

    spi_master_queue #(.DEPTH(8), .TIMEOUT(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .tx_level    (tx_level),
        .rx_level    (rx_level),
        .busy        (busy),
        .timeout_err (timeout_err),
        .m_start     (m_start),
        .m_data_in   (m_data_in),
        .m_data_out  (m_data_out),
        .m_done      (m_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Master model: sampled and driven on the falling edge, done pulse lasts one cycle.
    always @(negedge clk) begin
        mdl_done = 1'b0;
        if (!rst_n) begin
            mdl_busy   = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (mdl_busy) begin
                if (mdl_cnt == 0) begin
                    mdl_busy = 1'b0;
                    if (master_respond) begin
                        mdl_done   = 1'b1;
                        m_data_out = mdl_cap ^ 8'h99;
                    end
                end else begin
                    mdl_cnt = mdl_cnt - 1;
                end
            end
            if (m_start) begin
                if (prev_start) dbl_start = dbl_start + 1;
                if (mdl_busy) start_in_wait = start_in_wait + 1;
                mdl_busy    = 1'b1;
                mdl_cnt     = mdl_delay;
                mdl_cap     = m_data_in;
                start_count = start_count + 1;
                start_cyc   = cyc;
                start_log.push_back(m_data_in);
            end
            prev_start = m_start;
            if (timeout_err) begin
                to_count = to_count + 1;
                to_cyc   = cyc;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        int guard;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        guard = 0;
        while (!tx_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        tests++;
        if (guard >= 500) begin
            fails++;
            $display("FAIL push_ready byte=%h tx_ready stayed %b, required 1", b, tx_ready);
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
        m_data_out = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (m_start !== 1'b0) begin fails++; $display("FAIL rst_m_start got %b want 0", m_start); end
        tests++; if (m_data_in !== 8'h00) begin fails++; $display("FAIL rst_m_data_in got %h want 00", m_data_in); end
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL rst_timeout_err got %b want 0", timeout_err); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
        tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL rst_tx_ready got %b want 1", tx_ready); end
        tests++; if (rx_valid !== 1'b0) begin fails++; $display("FAIL rst_rx_valid got %b want 0", rx_valid); end
        tests++; if (tx_level !== 4'd0) begin fails++; $display("FAIL rst_tx_level got %0d want 0", tx_level); end
        tests++; if (rx_level !== 4'd0) begin fails++; $display("FAIL rst_rx_level got %0d want 0", rx_level); end
    endtask

    task automatic test_single();
        int s0, guard;
        enable = 1'b1; mdl_delay = 2; master_respond = 1'b1;
        s0 = start_count;
        push_byte(8'hA5);
        tests++; if (m_start !== 1'b0) begin fails++; $display("FAIL single_early_start got %b want 0", m_start); end
        tests++; if (tx_level !== 4'd1) begin fails++; $display("FAIL single_tx_level got %0d want 1", tx_level); end
        @(negedge clk);
        tests++; if (m_start !== 1'b1) begin fails++; $display("FAIL single_start got %b want 1", m_start); end
        tests++; if (m_data_in !== 8'hA5) begin fails++; $display("FAIL single_data_in got %h want a5", m_data_in); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy got %b want 1", busy); end
        guard = 0;
        while (!rx_valid && guard < 100) begin @(negedge clk); guard++; end
        tests++; if (guard >= 100) begin fails++; $display("FAIL single_rx_wait rx_valid got %b want 1", rx_valid); end
        tests++; if (rx_data !== 8'h3C) begin fails++; $display("FAIL single_rx_data got %h want 3c", rx_data); end
        tests++; if (rx_level !== 4'd1) begin fails++; $display("FAIL single_rx_level got %0d want 1", rx_level); end
        tests++; if (start_count - s0 !== 1) begin fails++; $display("FAIL single_start_count got %0d want 1", start_count - s0); end
        rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
        tests++; if (rx_level !== 4'd0) begin fails++; $display("FAIL single_pop_level got %0d want 0", rx_level); end
    endtask

    task automatic test_burst();
        logic [7:0] exp_rx [8] = '{8'h98, 8'h9B, 8'h9A, 8'h9D, 8'h9C, 8'h9F, 8'h9E, 8'h91};
        int s0, l0, guard;
        enable = 1'b0;
        s0 = start_count; l0 = start_log.size();
        @(negedge clk);
        tx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tx_data = 8'(i + 1);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        tests++; if (tx_level !== 4'd8) begin fails++; $display("FAIL burst_tx_level got %0d want 8", tx_level); end
        tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL burst_tx_ready got %b want 0", tx_ready); end
        tx_valid = 1'b1; tx_data = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
        tests++; if (tx_level !== 4'd8) begin fails++; $display("FAIL burst_overflow_level got %0d want 8", tx_level); end
        enable = 1'b1;
        guard = 0;
        while (rx_level != 4'd8 && guard < 400) begin @(negedge clk); guard++; end
        tests++; if (guard >= 400) begin fails++; $display("FAIL burst_rx_fill rx_level got %0d want 8", rx_level); end
        tests++; if (start_count - s0 !== 8) begin fails++; $display("FAIL burst_starts got %0d want 8", start_count - s0); end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (start_log[l0 + i] !== 8'(i + 1)) begin
                fails++; $display("FAIL burst_order idx=%0d got %h want %h", i, start_log[l0 + i], 8'(i + 1));
            end
        end
        tests++; if (start_in_wait !== 0 || dbl_start !== 0) begin fails++; $display("FAIL burst_start_protocol in_wait=%0d double=%0d want 0/0", start_in_wait, dbl_start); end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (rx_data !== exp_rx[i]) begin fails++; $display("FAIL burst_rx idx=%0d got %h want %h", i, rx_data, exp_rx[i]); end
            rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
        end
        tests++; if (rx_level !== 4'd0) begin fails++; $display("FAIL burst_drain got %0d want 0", rx_level); end
    endtask

    task automatic test_backpressure();
        int s0, guard;
        enable = 1'b1; rx_ready = 1'b0;
        s0 = start_count;
        for (int i = 0; i < 10; i++) push_byte(8'(8'h10 + i));
        guard = 0;
        while (rx_level != 4'd8 && guard < 400) begin @(negedge clk); guard++; end
        tests++; if (guard >= 400) begin fails++; $display("FAIL bp_rx_fill rx_level got %0d want 8", rx_level); end
        repeat (50) @(negedge clk);
        tests++; if (start_count - s0 !== 8) begin fails++; $display("FAIL bp_starts got %0d want 8", start_count - s0); end
        tests++; if (tx_level !== 4'd2) begin fails++; $display("FAIL bp_tx_level got %0d want 2", tx_level); end
        tests++; if (rx_data !== 8'h89) begin fails++; $display("FAIL bp_rx_head got %h want 89", rx_data); end
        rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
        repeat (50) @(negedge clk);
        tests++; if (start_count - s0 !== 9) begin fails++; $display("FAIL bp_one_more got %0d want 9", start_count - s0); end
        tests++; if (rx_level !== 4'd8 || tx_level !== 4'd1) begin fails++; $display("FAIL bp_levels rx=%0d tx=%0d want 8/1", rx_level, tx_level); end
        rx_ready = 1'b1;
        guard = 0;
        while ((tx_level != 0 || busy || rx_level != 0) && guard < 400) begin @(negedge clk); guard++; end
        rx_ready = 1'b0;
        tests++; if (guard >= 400) begin fails++; $display("FAIL bp_drain tx=%0d rx=%0d want 0/0", tx_level, rx_level); end
    endtask

    task automatic test_timeout();
        int t0, guard;
        enable = 1'b0; master_respond = 1'b0;
        push_byte(8'h55);
        push_byte(8'h66);
        t0 = to_count;
        enable = 1'b1;
        guard = 0;
        while (!timeout_err && guard < 200) begin @(negedge clk); guard++; end
        tests++; if (guard >= 200) begin fails++; $display("FAIL to_wait timeout_err got %b want 1", timeout_err); end
        master_respond = 1'b1;
        tests++; if (rx_level !== 4'd0) begin fails++; $display("FAIL to_rx_level got %0d want 0", rx_level); end
        @(negedge clk);
        tests++; if (to_cyc - start_cyc !== 64) begin fails++; $display("FAIL to_latency got %0d want 64", to_cyc - start_cyc); end
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_pulse_width got %b want 0", timeout_err); end
        tests++; if (m_start !== 1'b1 || m_data_in !== 8'h66) begin fails++; $display("FAIL to_next_launch start=%b data=%h want 1/66", m_start, m_data_in); end
        guard = 0;
        while (!rx_valid && guard < 100) begin @(negedge clk); guard++; end
        tests++; if (rx_data !== 8'hFF || rx_level !== 4'd1) begin fails++; $display("FAIL to_second_rx data=%h level=%0d want ff/1", rx_data, rx_level); end
        tests++; if (to_count - t0 !== 1) begin fails++; $display("FAIL to_count got %0d want 1", to_count - t0); end
        rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
    endtask

    task automatic test_enable();
        int s0, l0, guard;
        enable = 1'b0; mdl_delay = 6;
        push_byte(8'h21); push_byte(8'h22); push_byte(8'h23);
        s0 = start_count; l0 = start_log.size();
        enable = 1'b1;
        guard = 0;
        while (!m_start && guard < 50) begin @(negedge clk); guard++; end
        enable = 1'b0;
        tests++; if (guard >= 50) begin fails++; $display("FAIL en_first_start m_start got %b want 1", m_start); end
        guard = 0;
        while (rx_level != 4'd1 && guard < 100) begin @(negedge clk); guard++; end
        tests++; if (rx_data !== 8'hB8) begin fails++; $display("FAIL en_rx_first got %h want b8", rx_data); end
        repeat (30) @(negedge clk);
        tests++; if (start_count - s0 !== 1 || tx_level !== 4'd2 || busy !== 1'b0) begin
            fails++; $display("FAIL en_hold starts=%0d tx=%0d busy=%b want 1/2/0", start_count - s0, tx_level, busy);
        end
        enable = 1'b1;
        guard = 0;
        while (rx_level != 4'd3 && guard < 200) begin @(negedge clk); guard++; end
        tests++; if (start_count - s0 !== 3) begin fails++; $display("FAIL en_resume got %0d want 3", start_count - s0); end
        tests++; if (start_log[l0 + 1] !== 8'h22 || start_log[l0 + 2] !== 8'h23) begin
            fails++; $display("FAIL en_order got %h %h want 22 23", start_log[l0 + 1], start_log[l0 + 2]);
        end
        rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
        tests++; if (rx_data !== 8'hBB) begin fails++; $display("FAIL en_rx_second got %h want bb", rx_data); end
        rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
        tests++; if (rx_data !== 8'hBA) begin fails++; $display("FAIL en_rx_third got %h want ba", rx_data); end
        rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
        mdl_delay = 2;
    endtask

    task automatic test_reset_mid();
        int guard;
        enable = 1'b0; mdl_delay = 20;
        push_byte(8'h31); push_byte(8'h32); push_byte(8'h33); push_byte(8'h34);
        enable = 1'b1;
        guard = 0;
        while (!m_start && guard < 50) begin @(negedge clk); guard++; end
        tests++; if (busy !== 1'b1 || tx_level !== 4'd3) begin fails++; $display("FAIL rm_pre busy=%b tx=%0d want 1/3", busy, tx_level); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (m_start !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            fails++; $display("FAIL rm_ctrl start=%b busy=%b to=%b want 0/0/0", m_start, busy, timeout_err);
        end
        tests++; if (tx_level !== 4'd0 || tx_ready !== 1'b1 || m_data_in !== 8'h00) begin
            fails++; $display("FAIL rm_tx tx=%0d ready=%b data=%h want 0/1/00", tx_level, tx_ready, m_data_in);
        end
        tests++; if (rx_level !== 4'd0 || rx_valid !== 1'b0) begin fails++; $display("FAIL rm_rx rx=%0d valid=%b want 0/0", rx_level, rx_valid); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        spurious_done = 1'b1;
        @(negedge clk);
        spurious_done = 1'b0;
        @(negedge clk);
        tests++; if (rx_level !== 4'd0 || rx_valid !== 1'b0) begin fails++; $display("FAIL rm_spurious rx=%0d valid=%b want 0/0", rx_level, rx_valid); end
        tests++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin fails++; $display("FAIL rm_idle busy=%b to=%b want 0/0", busy, timeout_err); end
        mdl_delay = 2;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_timeout();
        test_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
